// File: rtl/enc_bundler_cc.sv
// Encoder bundling stage: accumulates per-dimension hit counts of bound sparse HVs over one
// sample, thresholds them into a single encoded HV and offers it on a valid/ready port.
module enc_bundler_cc #(
  parameter int HV_DIM          = 1024,
  parameter int FEATURES_PER_CC = 8,
  parameter int NUM_CC          = 16,
  parameter int CNT_W           = $clog2(NUM_CC * FEATURES_PER_CC + 1)
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start_bundling,
  input  logic [CNT_W-1:0]     thr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [HV_DIM-1:0]    shifted_hv [0:FEATURES_PER_CC-1],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [HV_DIM-1:0]    encoded_hv,
  output logic                 busy
);

  localparam int POP_W  = $clog2(FEATURES_PER_CC + 1);
  localparam int SUM_W  = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam int BEAT_W = (NUM_CC > 1) ? $clog2(NUM_CC) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_CC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_THRESH = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_cnt_reg;
  logic [CNT_W-1:0]    thr_reg;
  logic [CNT_W-1:0]    cnt_reg  [HV_DIM];
  logic [CNT_W-1:0]    cnt_next [HV_DIM];
  logic [HV_DIM-1:0]   hit;
  logic [HV_DIM-1:0]   encoded_reg;
  logic                out_valid_reg;
  logic                accept;

  // A beat coinciding with start_bundling is dropped: the restart wins.
  assign accept     = in_valid && (state_reg == S_ACCUM) && !start_bundling;
  assign in_ready   = (state_reg == S_ACCUM);
  assign busy       = (state_reg != S_IDLE);
  assign out_valid  = out_valid_reg;
  assign encoded_hv = encoded_reg;

  genvar gi;
  generate
    for (gi = 0; gi < HV_DIM; gi++) begin : g_dim
      logic [POP_W-1:0] pop;
      logic [SUM_W-1:0] sum;

      always_comb begin
        pop = '0;
        for (int f = 0; f < FEATURES_PER_CC; f++) begin
          pop = pop + POP_W'(shifted_hv[f][gi]);
        end
      end

      assign sum          = SUM_W'(cnt_reg[gi]) + SUM_W'(pop);
      assign cnt_next[gi] = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
      assign hit[gi]      = (cnt_reg[gi] >= thr_reg);
    end
  endgenerate

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int d = 0; d < HV_DIM; d++) cnt_reg[d] <= '0;
    end else if (start_bundling) begin
      for (int d = 0; d < HV_DIM; d++) cnt_reg[d] <= '0;
    end else if (accept) begin
      for (int d = 0; d < HV_DIM; d++) cnt_reg[d] <= cnt_next[d];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= S_IDLE;
      beat_cnt_reg  <= '0;
      thr_reg       <= '0;
      encoded_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (start_bundling) begin
      state_reg     <= S_ACCUM;
      beat_cnt_reg  <= '0;
      thr_reg       <= thr;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          out_valid_reg <= 1'b0;
        end
        S_ACCUM: begin
          if (accept) begin
            if (beat_cnt_reg == LAST_BEAT) begin
              beat_cnt_reg <= '0;
              state_reg    <= S_THRESH;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        S_THRESH: begin
          encoded_reg   <= hit;
          out_valid_reg <= 1'b1;
          state_reg     <= S_OUT;
        end
        S_OUT: begin
          if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_bundler_cc.sv
// Randomized self-checking bench for enc_bundler_cc against a per-dimension counting model.
module tb_enc_bundler_cc;

  localparam int HV_DIM = 16;
  localparam int FPC    = 2;
  localparam int NCC    = 3;
  localparam int CNT_W  = $clog2(NCC * FPC + 1);

  logic               clk = 1'b0;
  logic               nrst;
  logic               start_bundling;
  logic [CNT_W-1:0]   thr;
  logic               in_valid;
  logic               in_ready;
  logic [HV_DIM-1:0]  shifted_hv [0:FPC-1];
  logic               out_valid;
  logic               out_ready;
  logic [HV_DIM-1:0]  encoded_hv;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;
  int sample_no = 0;

  logic [HV_DIM-1:0] bts [0:NCC-1][0:FPC-1];

  enc_bundler_cc #(
    .HV_DIM(HV_DIM), .FEATURES_PER_CC(FPC), .NUM_CC(NCC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .nrst(nrst), .start_bundling(start_bundling), .thr(thr),
    .in_valid(in_valid), .in_ready(in_ready), .shifted_hv(shifted_hv),
    .out_valid(out_valid), .out_ready(out_ready), .encoded_hv(encoded_hv), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: count hits per dimension over all beats, saturate, then compare to threshold.
  function automatic logic [HV_DIM-1:0] model(input int thr_v);
    logic [HV_DIM-1:0] r;
    r = '0;
    for (int d = 0; d < HV_DIM; d++) begin
      int c;
      c = 0;
      for (int b = 0; b < NCC; b++)
        for (int f = 0; f < FPC; f++)
          c += int'(bts[b][f][d]);
      if (c > (1 << CNT_W) - 1) c = (1 << CNT_W) - 1;
      r[d] = (c >= thr_v);
    end
    return r;
  endfunction

  task automatic random_beats();
    for (int b = 0; b < NCC; b++)
      for (int f = 0; f < FPC; f++)
        bts[b][f] = HV_DIM'($urandom);
  endtask

  task automatic start_sample(input int thr_v);
    start_bundling = 1'b1;
    thr = CNT_W'(thr_v);
    step();
    start_bundling = 1'b0;
    check("in_ready_after_start", 32'(in_ready), 32'd1);
    check("out_valid_after_start", 32'(out_valid), 32'd0);
  endtask

  task automatic feed_beat(input int b, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      shifted_hv[0] = HV_DIM'($urandom);
      shifted_hv[1] = HV_DIM'($urandom);
      step();
      check("in_ready_in_gap", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b1;
    shifted_hv[0] = bts[b][0];
    shifted_hv[1] = bts[b][1];
    step();
    in_valid = 1'b0;
  endtask

  // Feeds the stored beats after start, then checks latency, hold under backpressure, handshake.
  task automatic finish_sample(input int thr_v, input int gap, input int hold, input int first_beat);
    logic [HV_DIM-1:0] exp_hv;
    exp_hv = model(thr_v);
    for (int b = first_beat; b < NCC; b++) feed_beat(b, gap);
    check("out_valid_T+1", 32'(out_valid), 32'd0);
    check("in_ready_thresh", 32'(in_ready), 32'd0);
    step();
    check("out_valid_T+2", 32'(out_valid), 32'd1);
    check("encoded_hv", 32'(encoded_hv), 32'(exp_hv));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      shifted_hv[0] = HV_DIM'($urandom);
      shifted_hv[1] = HV_DIM'($urandom);
      out_ready = 1'b0;
      step();
      check("out_valid_hold", 32'(out_valid), 32'd1);
      check("encoded_hold", 32'(encoded_hv), 32'(exp_hv));
      check("in_ready_out", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("encoded_after_hs", 32'(encoded_hv), 32'(exp_hv));
    $display("sample %0d thr=%0d gap=%0d hold=%0d exp=%h got=%h", sample_no, thr_v, gap, hold,
             exp_hv, encoded_hv);
    sample_no++;
  endtask

  initial begin
    nrst = 1'b0;
    start_bundling = 1'b0;
    thr = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    shifted_hv[0] = '0;
    shifted_hv[1] = '0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_encoded", 32'(encoded_hv), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    nrst = 1'b1;
    step();

    // Directed sample from the spec table, thr=2 -> 16'h0003.
    bts[0][0] = 16'h000F; bts[0][1] = 16'h0003;
    bts[1][0] = 16'h0001; bts[1][1] = 16'h0000;
    bts[2][0] = 16'h0000; bts[2][1] = 16'h0000;
    check("model_directed", 32'(model(2)), 32'h0003);
    start_sample(2);
    finish_sample(2, 0, 0, 0);
    start_sample(2);
    finish_sample(2, 2, 0, 0);

    // Saturation boundary: all ones give count 6.
    for (int b = 0; b < NCC; b++) begin bts[b][0] = 16'hFFFF; bts[b][1] = 16'hFFFF; end
    start_sample(6);
    finish_sample(6, 0, 5, 0);
    start_sample(7);
    finish_sample(7, 0, 0, 0);
    start_sample(0);
    finish_sample(0, 1, 1, 0);

    // Restart mid-sample: the beat presented with start_bundling is dropped.
    random_beats();
    start_sample(3);
    feed_beat(0, 0);
    feed_beat(1, 0);
    random_beats();
    start_bundling = 1'b1;
    thr = CNT_W'(3);
    in_valid = 1'b1;
    shifted_hv[0] = 16'hFFFF;
    shifted_hv[1] = 16'hFFFF;
    step();
    start_bundling = 1'b0;
    in_valid = 1'b0;
    check("restart_in_ready", 32'(in_ready), 32'd1);
    finish_sample(3, 0, 2, 0);

    // Randomized samples.
    for (int s = 0; s < 20; s++) begin
      int t;
      t = int'($urandom_range(0, 7));
      random_beats();
      start_sample(t);
      finish_sample(t, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        in_valid = 1'b1;
        shifted_hv[0] = HV_DIM'($urandom);
        step();
        in_valid = 1'b0;
        check("idle_in_ready", 32'(in_ready), 32'd0);
      end
    end

    // Asynchronous reset in the middle of accumulation.
    random_beats();
    start_sample(1);
    feed_beat(0, 0);
    nrst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_encoded", 32'(encoded_hv), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    step();
    nrst = 1'b1;
    step();
    check("postrst_in_ready", 32'(in_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
